// File: rtl/aes_enc_pkg.sv
// Shared types, constants and helpers for the iterative AES-128 encryption core.
// Optional macro AES_ROUND_SPLIT_EN (used by aes_enc_round and aes_cipher_core)
// splits each round across two cycles.
package aes_enc_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} aes_state_e;

    localparam int unsigned NR = 10;
    // Last round that still includes MixColumns.
    localparam logic [3:0] LastFullRound = 4'(NR - 1);

    // Forward S-box. Entry b sits at bits [8b:8b+7].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Multiply by {02} in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    // Bit offset of state byte (row, col) in the column-major 128-bit layout.
    function automatic int unsigned byte_off(input int unsigned row, input int unsigned col);
        return 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// Combinational AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// final_round bypasses MixColumns. With AES_ROUND_SPLIT_EN the SubBytes result is
// exported on sub_out and the remaining steps operate on sub_in instead.
module aes_enc_round
    import aes_enc_pkg::*;
(
    input  logic [0:127] state_in,
`ifdef AES_ROUND_SPLIT_EN
    input  logic [0:127] sub_in,
    output logic [0:127] sub_out,
`endif
    input  logic [0:127] round_key,
    input  logic         final_round,
    output logic [0:127] round_out
);

    logic [0:127] sb;
    logic [0:127] sr_in;
    logic [0:127] sr;
    logic [0:127] mc;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign sb[8*i +: 8] = sub_byte(state_in[8*i +: 8]);
    end

`ifdef AES_ROUND_SPLIT_EN
    assign sub_out = sb;
    assign sr_in   = sub_in;
`else
    assign sr_in   = sb;
`endif

    // out(r,c) = in(r,(c+r) mod 4)
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
        for (genvar r = 0; r < 4; r++) begin : g_sr_row
            assign sr[byte_off(r, c) +: 8] = sr_in[byte_off(r, (c + r) % 4) +: 8];
        end
    end

    // {02,03,01,01} circulant per column
    for (genvar c = 0; c < 4; c++) begin : g_mc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[byte_off(0, c) +: 8];
        assign a1 = sr[byte_off(1, c) +: 8];
        assign a2 = sr[byte_off(2, c) +: 8];
        assign a3 = sr[byte_off(3, c) +: 8];
        assign mc[byte_off(0, c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc[byte_off(1, c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc[byte_off(2, c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc[byte_off(3, c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    assign round_out = (final_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core, one round per clock, level start/done handshake.
// Optional macro AES_ROUND_SPLIT_EN: two cycles per round (SubBytes registered first).
module aes_cipher_core
    import aes_enc_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            AES_START,
    input  logic [0:127]    AES_PLAIN,
    input  logic [0:1407]   AES_KEYSCHED,
    output logic [0:127]    AES_CIPHER,
    output logic            AES_DONE,
    output logic            AES_BUSY
);

    aes_state_e   fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [0:127] st_q, st_d;
    logic [0:127] cipher_q, cipher_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic [0:127] round_key;
    logic [0:127] rnd_out;
    logic         round_step;  // high on the edge that completes a round
    logic [0:127] step_val;    // value loaded into the state register while busy

    assign round_key = AES_KEYSCHED[128 * round_q +: 128];

`ifdef AES_ROUND_SPLIT_EN
    logic         phase_q, phase_d;
    logic [0:127] sub_out;

    aes_enc_round u_round (
        .state_in    (st_q),
        .sub_in      (st_q),
        .sub_out     (sub_out),
        .round_key   (round_key),
        .final_round (fsm_q == StFinal),
        .round_out   (rnd_out)
    );

    assign round_step = phase_q;
    assign step_val   = phase_q ? rnd_out : sub_out;
    assign phase_d    = ((fsm_q == StRound) || (fsm_q == StFinal)) ? ~phase_q : 1'b0;

    // Phase bit: 0 = SubBytes half, 1 = ShiftRows/MixColumns/AddRoundKey half.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) phase_q <= 1'b0;
        else          phase_q <= phase_d;
    end
`else
    aes_enc_round u_round (
        .state_in    (st_q),
        .round_key   (round_key),
        .final_round (fsm_q == StFinal),
        .round_out   (rnd_out)
    );

    assign round_step = 1'b1;
    assign step_val   = rnd_out;
`endif

    // Next-state logic for FSM, round counter, state and result registers.
    always_comb begin
        fsm_d    = fsm_q;
        round_d  = round_q;
        st_d     = st_q;
        cipher_d = cipher_q;
        unique case (fsm_q)
            StIdle: begin
                if (AES_START) begin
                    st_d    = AES_PLAIN ^ AES_KEYSCHED[0:127];
                    round_d = 4'd1;
                    fsm_d   = StRound;
                end
            end
            StRound: begin
                st_d = step_val;
                if (round_step) begin
                    round_d = round_q + 4'd1;
                    if (round_q == LastFullRound) fsm_d = StFinal;
                end
            end
            StFinal: begin
                st_d = step_val;
                if (round_step) begin
                    cipher_d = rnd_out;
                    fsm_d    = StDone;
                end
            end
            StDone: begin
                if (!AES_START) fsm_d = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
        done_d = (fsm_d == StDone);
        busy_d = (fsm_d == StRound) || (fsm_d == StFinal);
    end

    // State registers; outputs are registered copies of the next-state decode.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fsm_q    <= StIdle;
            round_q  <= 4'd0;
            st_q     <= '0;
            cipher_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            round_q  <= round_d;
            st_q     <= st_d;
            cipher_q <= cipher_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign AES_CIPHER = cipher_q;
    assign AES_DONE   = done_q;
    assign AES_BUSY   = busy_q;

endmodule

// File: doc/aes_cipher_core.md
# aes_cipher_core

Iterative AES-128 encryption engine, the forward-direction counterpart of the decryption datapath in the lab 9 AES hardware. Takes a 128-bit plaintext and a pre-expanded 11-round key schedule, then runs the initial AddRoundKey and 10 rounds of SubBytes, ShiftRows, MixColumns (omitted in round 10) and AddRoundKey, one round per clock. Sits beside the decryption core behind the Avalon AES interface, driven by a level start/done handshake.

## Interface
- NR, 10, number of cipher rounds (AES-128 only; other values unsupported)
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- AES_START  in  1  level request; sampled only in IDLE
- AES_PLAIN  in  [0:127]  plaintext; byte i at bits [8i:8i+7], byte i = row (i mod 4), column (i div 4)
- AES_KEYSCHED  in  [0:1407]  round key k at bits [128k:128k+127], k = 0..10; stable from start until done
- AES_CIPHER  out  [0:127]  ciphertext, same byte layout as AES_PLAIN
- AES_DONE  out  1  result valid; held while AES_START stays high
- AES_BUSY  out  1  high in any state other than IDLE and DONE

## Operation
- State byte layout is column-major, matching the decryption path.
- ShiftRows: out(r,c) = in(r,(c+r) mod 4); row 0 unshifted, row 1 left by 1, row 2 by 2, row 3 by 3.
- MixColumns: per column, GF(2^8) multiply by {02,03,01,01} circulant; xtime reduction polynomial 0x11B.
- FSM states: IDLE, ROUND, FINAL, DONE.
  - IDLE and AES_START=1: state_reg <= AES_PLAIN ^ rk0, round <= 1, go to ROUND.
  - ROUND: state_reg <= full round using rk[round], round++; after round 9, go to FINAL.
  - FINAL: state_reg <= round without MixColumns using rk10; AES_CIPHER <= that value; go to DONE.
  - DONE: AES_DONE=1. When AES_START=0, go to IDLE.
- AES_START is ignored in ROUND and FINAL. AES_PLAIN and AES_KEYSCHED are not sampled after the capture edge, except AES_KEYSCHED, which is read per round.
- Round counter is 4 bits and never exceeds 10.

## Timing
- Reset values: state IDLE, round 0, state_reg 0, AES_CIPHER 0, AES_DONE 0, AES_BUSY 0.
- Latency: capture edge E0. AES_DONE and AES_CIPHER are valid after edge E10 (10 cycles).
- AES_CIPHER holds its value through DONE and IDLE until the next FINAL edge.
- Back-to-back operation: start must drop for at least one cycle; AES_START=1 in the first IDLE cycle starts a new operation.
- RESET_N asserted mid-operation: immediate return to reset values; no partial result is exposed.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- AES_ROUND_SPLIT_EN defined:
  - Each round takes two cycles. The first cycle registers SubBytes; the second applies ShiftRows, MixColumns and AddRoundKey.
  - A phase bit is added. Latency is 20 cycles.
  - Use this to meet timing on slow fabric.
- Undefined: one round per cycle, latency 10 cycles.
- Functional results are identical in both modes.

## Structure
- Package aes_enc_pkg holds:
  - the FSM state enum
  - NR = 10
  - the 256-entry S-box constant
  - the xtime function
  - the byte-index helper (row, col to bit offset)
- Sub-module aes_enc_round: combinational SubBytes, ShiftRows, MixColumns and AddRoundKey with a final_round input that bypasses MixColumns. In split mode it exposes the SubBytes output separately.
- The top level holds only the FSM, the counter and the registers.

## Test plan
- FIPS-197 C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f (schedule from the bench model) -> AES_CIPHER 69c4e0d86a7b0430d8cdb78070b4c55a, AES_DONE rising exactly 10 cycles after capture (20 with AES_ROUND_SPLIT_EN).
- FIPS-197 App. B: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32; state after round 1 matches the App. B trace.
- Hold AES_START high 30 cycles past done -> AES_DONE stays 1, AES_CIPHER stable. Drop start -> IDLE next edge, AES_DONE 0, AES_CIPHER unchanged.
- Change AES_PLAIN and pulse start while BUSY -> ignored; result is still the original ciphertext.
- Assert RESET_N low at cycle 5 of an operation -> AES_CIPHER 0, AES_DONE 0, AES_BUSY 0 immediately. Restart -> correct result.
- Random plaintext/key pairs, 1000 iterations -> matches the software model, and decrypting through the inverse core returns the plaintext.
